pad_attr_readback: RTL and testbench

- Reader at the far end of the pad-attribute path: pad attribute configuration flows down the hierarchy to generic pad attribute cells, and this block reads it back from them.
- On request, sequentially scans NumPads pad attribute cells through a req/ack read port and emits each captured pad type on a valid/ready stream.
- Sits in the pinmux alongside the pad attribute instances; feeds DV/status logic.

---
 rtl/pinmux_pkg.sv | 31 +++
 rtl/pad_attr_readback_timer.sv | 30 +++
 rtl/pad_attr_readback.sv | 176 +++++++++++++++++
 tb/tb_pad_attr_readback.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pinmux_pkg.sv
// Shared pinmux types for the pad attribute readback path: pad type encodings,
// readback FSM states and the stream beat layout.
package pinmux_pkg;

    typedef enum int {
        PadTypeA = 1,
        PadTypeB = 2
    } pad_type_e;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StWait,
        StOut,
        StDone
    } readback_state_e;

    // Wide enough for the largest legal pad count (256); narrower tops slice it.
    localparam int unsigned MaxIdxW = 8;

    typedef struct packed {
        logic [MaxIdxW-1:0] idx;
        logic [31:0]        data;
        logic               err;
    } pad_attr_beat_t;

    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pad_attr_readback_timer.sv
// Loadable, clearable down-counter; o_expired flags the terminal count (zero).
module pad_attr_readback_timer #(
    parameter int unsigned Width = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [Width-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_expired
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - Width'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/pad_attr_readback.sv
// Scans NumPads pad attribute cells over a req/ack port and streams each pad type out.
// Optional PAD_ATTR_READBACK_CHECK_EN adds a mismatch flag/counter against ExpectedPadType.
//   state  | meaning
//   IDLE   | waiting for start_i
//   REQ    | request raised for pad idx, timeout armed
//   WAIT   | waiting for ack or timeout
//   OUT    | beat presented, waiting for out_ready_i
//   DONE   | single-cycle done_o pulse
module pad_attr_readback
    import pinmux_pkg::*;
#(
    parameter int unsigned NumPads         = 8,
    parameter int unsigned TimeoutCycles   = 16,
    parameter int          ExpectedPadType = 0,
    parameter int unsigned IdxW            = idx_width(NumPads)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            attr_req_o,
    output logic [IdxW-1:0] attr_idx_o,
    input  logic [31:0]     attr_rdata_i,
    input  logic            attr_ack_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [IdxW-1:0] out_idx_o,
    output logic [31:0]     out_data_o,
    output logic            out_err_o
`ifdef PAD_ATTR_READBACK_CHECK_EN
    ,
    output logic            mismatch_o,
    output logic [IdxW:0]   mismatch_cnt_o
`endif
);

    localparam int unsigned TmrW = idx_width(TimeoutCycles);

    readback_state_e r_state;
    logic [IdxW-1:0] r_idx;
    logic            r_busy;
    logic            r_done;
    logic            r_req;
    logic            r_valid;
    pad_attr_beat_t  r_beat;

    logic w_start;
    logic w_last;
    logic w_handshake;
    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_tmr_expired;
    logic w_unused_idx;

    assign w_start     = (r_state == StIdle) && start_i;
    assign w_last      = (r_idx == IdxW'(NumPads - 1));
    assign w_handshake = r_valid && out_ready_i;
    assign w_tmr_load  = (r_state == StReq);
    assign w_tmr_dec   = (r_state == StWait) && !attr_ack_i;

    // Loaded with TimeoutCycles-1 so the zero compare lands on the last allowed WAIT cycle.
    pad_attr_readback_timer #(
        .Width (TmrW)
    ) u_timer (
        .i_clk      (clk_i),
        .i_rst      (rst_i),
        .i_clr      (w_start),
        .i_load     (w_tmr_load),
        .i_load_val (TmrW'(TimeoutCycles - 1)),
        .i_dec      (w_tmr_dec),
        .o_expired  (w_tmr_expired)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= StIdle;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_req   <= 1'b0;
            r_valid <= 1'b0;
            r_beat  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_req   <= 1'b1;
                        r_state <= StReq;
                    end
                end
                StReq: begin
                    r_state <= StWait;
                end
                StWait: begin
                    // An ack on the expiry cycle still counts as a good read.
                    if (attr_ack_i) begin
                        r_beat  <= '{idx: MaxIdxW'(r_idx), data: attr_rdata_i, err: 1'b0};
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= StOut;
                    end else if (w_tmr_expired) begin
                        r_beat  <= '{idx: MaxIdxW'(r_idx), data: 32'd0, err: 1'b1};
                        r_req   <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= StOut;
                    end
                end
                StOut: begin
                    if (out_ready_i) begin
                        r_valid <= 1'b0;
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= StDone;
                        end else begin
                            r_idx   <= r_idx + IdxW'(1);
                            r_req   <= 1'b1;
                            r_state <= StReq;
                        end
                    end
                end
                StDone: begin
                    r_state <= StIdle;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign attr_req_o  = r_req;
    assign attr_idx_o  = r_idx;
    assign out_valid_o = r_valid;
    assign out_idx_o   = r_beat.idx[IdxW-1:0];
    assign out_data_o  = r_beat.data;
    assign out_err_o   = r_beat.err;
    assign w_unused_idx = ^r_beat.idx;

`ifdef PAD_ATTR_READBACK_CHECK_EN
    localparam logic [31:0] ExpData = ExpectedPadType;

    logic          r_mismatch;
    logic [IdxW:0] r_mismatch_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else if (w_start) begin
            r_mismatch     <= 1'b0;
            r_mismatch_cnt <= '0;
        end else if (w_handshake && (r_beat.err || (r_beat.data != ExpData))) begin
            r_mismatch <= 1'b1;
            if (r_mismatch_cnt != '1) begin
                r_mismatch_cnt <= r_mismatch_cnt + (IdxW + 1)'(1);
            end
        end
    end

    assign mismatch_o     = r_mismatch;
    assign mismatch_cnt_o = r_mismatch_cnt;
`else
    logic [31:0] w_unused_exp;
    logic        w_unused_hs;
    assign w_unused_exp = ExpectedPadType;
    assign w_unused_hs  = w_handshake;
`endif

endmodule

// File: tb/tb_pad_attr_readback.sv
// Randomized self-checking bench for pad_attr_readback: a 4-pad instance and a 1-pad,
// 1-cycle-timeout instance, both driven by behavioural pad responders.
module tb_pad_attr_readback;
    import pinmux_pkg::*;

    localparam int N   = 4;
    localparam int T   = 16;
    localparam int EXP = 2;
    localparam int IW  = 2;
    localparam int T1  = 1;

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [31:0]   data;
        logic          err;
    } beat_t;

    logic clk_i = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic          start_i = 1'b0, attr_ack_i = 1'b0, out_ready_i = 1'b1;
    logic [31:0]   attr_rdata_i = '0;
    logic          busy_o, done_o, attr_req_o, out_valid_o, out_err_o;
    logic [IW-1:0] attr_idx_o, out_idx_o;
    logic [31:0]   out_data_o;
`ifdef PAD_ATTR_READBACK_CHECK_EN
    logic          mismatch_o;
    logic [IW:0]   mismatch_cnt_o;
`endif

    logic          start1 = 1'b0, ack1 = 1'b0, ready1 = 1'b1;
    logic [31:0]   rdata1 = '0;
    logic          busy1, done1, req1, valid1, err1;
    logic [0:0]    aidx1, oidx1;
    logic [31:0]   data1;
`ifdef PAD_ATTR_READBACK_CHECK_EN
    logic          mm1;
    logic [1:0]    mmc1;
`endif

    pad_attr_readback #(.NumPads(N), .TimeoutCycles(T), .ExpectedPadType(EXP)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o), .done_o(done_o),
        .attr_req_o(attr_req_o), .attr_idx_o(attr_idx_o), .attr_rdata_i(attr_rdata_i),
        .attr_ack_i(attr_ack_i), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_idx_o(out_idx_o), .out_data_o(out_data_o), .out_err_o(out_err_o)
`ifdef PAD_ATTR_READBACK_CHECK_EN
        , .mismatch_o(mismatch_o), .mismatch_cnt_o(mismatch_cnt_o)
`endif
    );

    pad_attr_readback #(.NumPads(1), .TimeoutCycles(T1), .ExpectedPadType(EXP)) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start1), .busy_o(busy1), .done_o(done1),
        .attr_req_o(req1), .attr_idx_o(aidx1), .attr_rdata_i(rdata1),
        .attr_ack_i(ack1), .out_valid_o(valid1), .out_ready_i(ready1),
        .out_idx_o(oidx1), .out_data_o(data1), .out_err_o(err1)
`ifdef PAD_ATTR_READBACK_CHECK_EN
        , .mismatch_o(mm1), .mismatch_cnt_o(mmc1)
`endif
    );

    int    n_checks = 0, n_fail = 0;
    int    pad_data[N];
    int    pad_dly[N];
    bit    rand_ready = 1'b0;
    beat_t beats[$];
    int    cyc = 0, done_cnt = 0, busy_rise = 0, done_cyc = 0, req_age = 0;
    bit    prev_busy = 1'b0, prev_req = 1'b0;
    int    dly1 = 1, data1_v = 0, age1 = 0, done1_cnt = 0, rise1 = 0, dcyc1 = 0, nbeat1 = 0;
    bit    prev_req1 = 1'b0, prev_busy1 = 1'b0;
    logic [33:0] beat1;

    // Pad cells: ack held from `delay` cycles after the request rises; garbage data otherwise.
    initial forever begin
        @(negedge clk_i);
        if (attr_req_o) begin
            req_age      = prev_req ? req_age + 1 : 0;
            attr_ack_i   = (req_age >= pad_dly[attr_idx_o]);
            attr_rdata_i = attr_ack_i ? pad_data[attr_idx_o] : $urandom;
        end else begin
            attr_ack_i   = 1'b0;
            attr_rdata_i = $urandom;
        end
        prev_req = attr_req_o;
        if (req1) begin
            age1   = prev_req1 ? age1 + 1 : 0;
            ack1   = (age1 >= dly1);
            rdata1 = ack1 ? data1_v : $urandom;
        end else begin
            ack1   = 1'b0;
            rdata1 = $urandom;
        end
        prev_req1 = req1;
        if (rand_ready) out_ready_i = 1'($urandom_range(0, 1));
    end

    initial forever begin
        @(negedge clk_i);
        #1;
        cyc++;
        if (busy_o && !prev_busy) busy_rise = cyc;
        if (done_o) begin done_cnt++; done_cyc = cyc; end
        if (out_valid_o && out_ready_i) beats.push_back({out_idx_o, out_data_o, out_err_o});
        prev_busy = busy_o;
        if (busy1 && !prev_busy1) rise1 = cyc;
        if (done1) begin done1_cnt++; dcyc1 = cyc; end
        if (valid1 && ready1) begin nbeat1++; beat1 = {oidx1, data1, err1}; end
        prev_busy1 = busy1;
    end

    function automatic beat_t model_beat(input int i);
        beat_t b;
        b.idx = IW'(i);
        if (pad_dly[i] <= T) begin b.data = pad_data[i]; b.err = 1'b0; end
        else begin b.data = 32'd0; b.err = 1'b1; end
        return b;
    endfunction

    // Busy-rise to done with ready always high: REQ + WAIT cycles + OUT per pad.
    function automatic int model_scan_cycles();
        int s = 0;
        for (int i = 0; i < N; i++) s += 2 + ((pad_dly[i] <= T) ? pad_dly[i] : T);
        return s;
    endfunction

    task automatic run_scan(output bit timed_out);
        beats.delete();
        done_cnt = 0;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk_i);
            if (done_cnt != 0) begin timed_out = 1'b0; break; end
        end
        repeat (3) @(negedge clk_i);
    endtask

    task automatic test_reset();
        @(negedge clk_i); rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_o, attr_req_o, attr_idx_o, out_valid_o, out_idx_o, out_data_o, out_err_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b req=%b valid=%b data=%h err=%b required all 0",
                     busy_o, done_o, attr_req_o, out_valid_o, out_data_o, out_err_o);
        end
        n_checks++;
        if ({busy1, done1, req1, aidx1, valid1, oidx1, data1, err1} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs_1pad got busy=%b req=%b valid=%b data=%h required all 0", busy1, req1, valid1, data1);
        end
`ifdef PAD_ATTR_READBACK_CHECK_EN
        n_checks++;
        if (mismatch_o !== 1'b0 || mismatch_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL reset_mismatch got %b/%0d required 0/0", mismatch_o, mismatch_cnt_o);
        end
`endif
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0 || attr_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got busy=%b req=%b required 0 0", busy_o, attr_req_o);
        end
    endtask

    task automatic check_scan(input string name, input bit timed_out, input bit check_time);
        n_checks++;
        if (timed_out) begin n_fail++; $display("FAIL %s_timeout no done_o within budget", name); end
        n_checks++;
        if (beats.size() != N) begin
            n_fail++;
            $display("FAIL %s_beat_count got %0d required %0d", name, beats.size(), N);
        end
        for (int i = 0; i < N && i < beats.size(); i++) begin
            beat_t e;
            e = model_beat(i);
            n_checks++;
            if (beats[i] !== e) begin
                n_fail++;
                $display("FAIL %s_beat%0d got idx=%0d data=%h err=%b required idx=%0d data=%h err=%b",
                         name, i, beats[i].idx, beats[i].data, beats[i].err, e.idx, e.data, e.err);
            end
        end
        n_checks++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_count got %0d required 1", name, done_cnt); end
        if (check_time) begin
            n_checks++;
            if (done_cyc - busy_rise != model_scan_cycles()) begin
                n_fail++;
                $display("FAIL %s_latency got %0d required %0d", name, done_cyc - busy_rise, model_scan_cycles());
            end
        end
    endtask

    task automatic test_basic();
        bit to;
        for (int i = 0; i < N; i++) begin pad_data[i] = i + 1; pad_dly[i] = 1; end
        run_scan(to);
        check_scan("basic", to, 1'b1);
        n_checks++;
        if (done_cyc - busy_rise != 12) begin
            n_fail++;
            $display("FAIL basic_done_12 got %0d required 12", done_cyc - busy_rise);
        end
    endtask

    task automatic test_timeout();
        bit to;
        for (int i = 0; i < N; i++) begin pad_data[i] = i + 1; pad_dly[i] = 1; end
        pad_dly[2] = 1000;
        run_scan(to);
        check_scan("timeout", to, 1'b1);
        // Ack exactly on the last allowed WAIT cycle wins; one cycle later is a timeout.
        for (int i = 0; i < N; i++) pad_data[i] = $urandom;
        pad_dly[0] = T; pad_dly[1] = T + 1; pad_dly[2] = 1; pad_dly[3] = T - 1;
        run_scan(to);
        check_scan("timeout_edge", to, 1'b1);
    endtask

    task automatic test_stall();
        bit    seen;
        beat_t e;
        for (int i = 0; i < N; i++) begin pad_data[i] = $urandom; pad_dly[i] = 1; end
        out_ready_i = 1'b1;
        beats.delete();
        done_cnt = 0;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (attr_req_o && attr_idx_o == 1) seen = 1'b1;
        end
        out_ready_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (out_valid_o) seen = 1'b1;
        end
        n_checks++;
        if (!seen) begin n_fail++; $display("FAIL stall_wait_valid out_valid_o never rose"); end
        e = model_beat(1);
        for (int c = 0; c < 5; c++) begin
            if (c > 0) @(negedge clk_i);
            n_checks++;
            if (out_valid_o !== 1'b1 || {out_idx_o, out_data_o, out_err_o} !== e || attr_req_o !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d got valid=%b idx=%0d data=%h err=%b req=%b required 1 %0d %h %b 0",
                         c, out_valid_o, out_idx_o, out_data_o, out_err_o, attr_req_o, e.idx, e.data, e.err);
            end
        end
        out_ready_i = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk_i);
            if (done_cnt != 0) seen = 1'b1;
        end
        repeat (3) @(negedge clk_i);
        check_scan("stall", !seen, 1'b0);
    endtask

    task automatic test_start_ignored();
        bit seen;
        for (int i = 0; i < N; i++) begin pad_data[i] = $urandom; pad_dly[i] = 1; end
        beats.delete();
        done_cnt = 0;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (4) @(negedge clk_i);
        start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (done_o) seen = 1'b1;
        end
        n_checks++;
        if (!seen || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_falls_with_done got seen=%b busy=%b required 1 0", seen, busy_o);
        end
        start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        repeat (20) @(negedge clk_i);
        check_scan("start_ignored", !seen, 1'b0);
        n_checks++;
        if (busy_o !== 1'b0 || attr_req_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_restart got busy=%b req=%b required 0 0", busy_o, attr_req_o);
        end
    endtask

    task automatic test_reset_mid();
        bit seen;
        for (int i = 0; i < N; i++) begin pad_data[i] = $urandom; pad_dly[i] = $urandom_range(1, 3); end
        beats.delete();
        done_cnt = 0;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 100 && !seen; k++) begin
            @(negedge clk_i);
            if (out_valid_o && out_idx_o == 2) seen = 1'b1;
        end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if (!seen || {busy_o, done_o, attr_req_o, out_valid_o, out_data_o, out_err_o} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_outputs got seen=%b busy=%b req=%b valid=%b data=%h required 1 and all 0",
                     seen, busy_o, attr_req_o, out_valid_o, out_data_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        repeat (3) @(negedge clk_i);
        n_checks++;
        if (done_cnt != 0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset_no_done got done_cnt=%0d busy=%b required 0 0", done_cnt, busy_o);
        end
        beats.delete();
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (attr_req_o) seen = 1'b1;
            else @(negedge clk_i);
        end
        n_checks++;
        if (!seen || attr_idx_o !== '0) begin
            n_fail++;
            $display("FAIL restart_idx got seen=%b idx=%0d required 1 0", seen, attr_idx_o);
        end
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk_i);
            if (done_cnt != 0) seen = 1'b1;
        end
        repeat (3) @(negedge clk_i);
        check_scan("restart", !seen, 1'b0);
    endtask

    task automatic test_random();
        bit to;
        rand_ready = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < N; i++) begin
                pad_data[i] = $urandom;
                pad_dly[i]  = $urandom_range(1, T + 4);
            end
            run_scan(to);
            check_scan("random", to, 1'b0);
        end
        rand_ready  = 1'b0;
        out_ready_i = 1'b1;
    endtask

    task automatic test_single();
        for (int s = 0; s < 2; s++) begin
            bit         ok;
            logic [33:0] e;
            dly1    = (s == 0) ? 1 : 2;
            data1_v = $urandom;
            ok      = (dly1 <= T1);
            e       = {1'b0, ok ? data1_v : 32'd0, !ok};
            done1_cnt = 0;
            nbeat1    = 0;
            @(negedge clk_i); start1 = 1'b1;
            @(negedge clk_i); start1 = 1'b0;
            for (int k = 0; k < 50 && done1_cnt == 0; k++) @(negedge clk_i);
            repeat (3) @(negedge clk_i);
            n_checks++;
            if (nbeat1 != 1 || beat1 !== e || done1_cnt != 1) begin
                n_fail++;
                $display("FAIL single_pad%0d got beats=%0d beat=%h done=%0d required 1 %h 1", s, nbeat1, beat1, done1_cnt, e);
            end
            n_checks++;
            if (dcyc1 - rise1 != 3) begin
                n_fail++;
                $display("FAIL single_pad%0d_latency got %0d required 3", s, dcyc1 - rise1);
            end
        end
    endtask

`ifdef PAD_ATTR_READBACK_CHECK_EN
    task automatic test_check();
        bit to;
        pad_data[0] = PadTypeB; pad_data[1] = PadTypeB; pad_data[2] = PadTypeA; pad_data[3] = PadTypeB;
        for (int i = 0; i < N; i++) pad_dly[i] = 1;
        run_scan(to);
        n_checks++;
        if (to || mismatch_o !== 1'b1 || mismatch_cnt_o !== 3'd1) begin
            n_fail++;
            $display("FAIL check_mismatch got %b/%0d required 1/1", mismatch_o, mismatch_cnt_o);
        end
        pad_data[2] = PadTypeB;
        pad_dly[3]  = 1000;
        @(negedge clk_i); start_i = 1'b1;
        @(negedge clk_i); start_i = 1'b0;
        n_checks++;
        if (mismatch_o !== 1'b0 || mismatch_cnt_o !== '0) begin
            n_fail++;
            $display("FAIL check_clear_on_start got %b/%0d required 0/0", mismatch_o, mismatch_cnt_o);
        end
        for (int k = 0; k < 200 && !done_o; k++) @(negedge clk_i);
        n_checks++;
        if (mismatch_o !== 1'b1 || mismatch_cnt_o !== 3'd1) begin
            n_fail++;
            $display("FAIL check_err_counts got %b/%0d required 1/1", mismatch_o, mismatch_cnt_o);
        end
    endtask
`endif

    initial begin
        for (int i = 0; i < N; i++) begin pad_data[i] = 0; pad_dly[i] = 1; end
        test_reset();
        test_basic();
        test_timeout();
        test_stall();
        test_start_ignored();
        test_reset_mid();
        test_random();
        test_single();
`ifdef PAD_ATTR_READBACK_CHECK_EN
        test_check();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
